// File: rtl/ospfb_axis_framer.sv
// AXI-Stream framing shim for the oversampled PFB top level: a small sample FIFO
// whose output is tagged with tlast at frame boundaries and a frame sequence number on tuser.
module ospfb_axis_framer #(
  parameter int WIDTH         = 16,
  parameter int FFT_LEN       = 512,
  parameter int DEC_FAC       = 384,
  parameter int FIFO_DEPTH    = 4,
  parameter int FRAME_CNT_WID = 16,
  parameter int DROP_ON_FULL  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     frame_sel,
  input  logic [WIDTH-1:0]         s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [FRAME_CNT_WID-1:0] m_tuser,
  output logic                     overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(FFT_LEN + 1);
  localparam logic [LW-1:0] LEN_FFT = LW'(FFT_LEN);
  localparam logic [LW-1:0] LEN_DEC = LW'(DEC_FAC);

  logic [WIDTH-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            cnt, len_active;
  logic [FRAME_CNT_WID-1:0] frame_cnt;
  logic                     full, empty, wr_en, rd_en, drop, is_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // In drop mode the source is never stalled; a full FIFO simply discards the sample.
  assign s_tready = !rst && en && ((DROP_ON_FULL != 0) || !full);
  assign wr_en    = s_tvalid && s_tready && !full;
  assign drop     = s_tvalid && s_tready && full;
  assign rd_en    = m_tvalid && m_tready;
  assign is_last  = (cnt == len_active - LW'(1));

  assign m_tvalid = !rst && !empty;
  assign m_tdata  = (rst || empty) ? '0 : mem[rd_ptr[AW-1:0]];
  assign m_tlast  = !rst && is_last;
  assign m_tuser  = rst ? '0 : frame_cnt;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

  // Frame length is reloaded from frame_sel only as the tlast sample leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      len_active <= LEN_FFT;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (is_last) begin
          cnt        <= '0;
          frame_cnt  <= frame_cnt + FRAME_CNT_WID'(1);
          len_active <= frame_sel ? LEN_DEC : LEN_FFT;
        end else begin
          cnt <= cnt + LW'(1);
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ospfb_axis_framer.sv
// Scoreboard bench for ospfb_axis_framer: back-pressure, drop-on-full and narrow
// frame-counter instances share one stimulus; each test checks one of them.
module tb_ospfb_axis_framer;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int FFT   = 512;
  localparam int DEC   = 384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, frame_sel, s_tvalid, m_tready;
  logic [W-1:0] s_tdata;

  logic rdy_a, vld_a, last_a, ovf_a; logic [W-1:0] data_a; logic [15:0] user_a;
  logic rdy_d, vld_d, last_d, ovf_d; logic [W-1:0] data_d; logic [15:0] user_d;
  logic rdy_w, vld_w, last_w, ovf_w; logic [W-1:0] data_w; logic [1:0]  user_w;

  ospfb_axis_framer #(.DROP_ON_FULL(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .frame_sel(frame_sel),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy_a),
    .m_tdata(data_a), .m_tvalid(vld_a), .m_tready(m_tready),
    .m_tlast(last_a), .m_tuser(user_a), .overflow(ovf_a));

  ospfb_axis_framer #(.DROP_ON_FULL(1)) u_drop (
    .clk(clk), .rst(rst), .en(en), .frame_sel(frame_sel),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy_d),
    .m_tdata(data_d), .m_tvalid(vld_d), .m_tready(m_tready),
    .m_tlast(last_d), .m_tuser(user_d), .overflow(ovf_d));

  ospfb_axis_framer #(.FRAME_CNT_WID(2)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .frame_sel(frame_sel),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy_w),
    .m_tdata(data_w), .m_tvalid(vld_w), .m_tready(m_tready),
    .m_tlast(last_w), .m_tuser(user_w), .overflow(ovf_w));

  int sel;
  logic obs_rdy, obs_vld, obs_last, obs_ovf; logic [W-1:0] obs_data; logic [15:0] obs_user;
  always_comb begin
    obs_rdy = rdy_a; obs_vld = vld_a; obs_last = last_a; obs_ovf = ovf_a;
    obs_data = data_a; obs_user = user_a;
    case (sel)
      1: begin
        obs_rdy = rdy_d; obs_vld = vld_d; obs_last = last_d; obs_ovf = ovf_d;
        obs_data = data_d; obs_user = user_d;
      end
      2: begin
        obs_rdy = rdy_w; obs_vld = vld_w; obs_last = last_w; obs_ovf = ovf_w;
        obs_data = data_w; obs_user = {14'd0, user_w};
      end
      default: ;
    endcase
  end

  typedef struct { logic [W-1:0] data; logic last; logic [15:0] user; } exp_t;
  exp_t sb[$];
  exp_t e;
  int m_cnt, m_len, m_frame, occ;
  int n_cmp = 0;
  int n_err = 0;
  int n_in, n_out;

  function void model_reset();
    sb.delete(); m_cnt = 0; m_len = FFT; m_frame = 0; occ = 0;
  endfunction

  // Expected framing is derived from each sample's position in the accepted stream.
  function void push_exp(input logic [W-1:0] d);
    exp_t x;
    x.data = d;
    x.last = (m_cnt == m_len - 1);
    x.user = 16'(m_frame % ((sel == 2) ? 4 : 65536));
    sb.push_back(x);
    if (x.last) begin
      m_cnt = 0; m_frame++; m_len = frame_sel ? DEC : FFT;
    end else m_cnt++;
  endfunction

  task automatic do_reset();
    s_tvalid = 1'b0; m_tready = 1'b0; en = 1'b1; rst = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_in = 0; n_out = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({rdy_a, vld_a, last_a, user_a, data_a} !== '0) begin
        n_err++;
        $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b last=%b user=%0d data=%0d, want all 0",
                 rdy_a, vld_a, last_a, user_a, data_a);
      end
      if (c > 0) begin
        n_cmp++;
        if ({rdy_d, vld_d, ovf_d} !== 3'b000) begin
          n_err++;
          $display("[TB] FAIL reset_drop: got rdy=%b vld=%b ovf=%b, want 000", rdy_d, vld_d, ovf_d);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; s_tvalid = 1'b0; model_reset();
    #1;
    n_cmp++;
    if ({rdy_a, vld_a, ovf_a, user_a} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      n_err++;
      $display("[TB] FAIL post_reset: got rdy=%b vld=%b ovf=%b user=%0d, want 1 0 0 0",
               rdy_a, vld_a, ovf_a, user_a);
    end
  endtask

  task automatic test_stream();
    sel = 0; do_reset(); frame_sel = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 1300 && n_out < 1024; c++) begin
      s_tvalid = (n_in < 1024); s_tdata = W'(n_in);
      #1;
      if (c == 0) begin
        n_cmp++;
        if (obs_vld !== 1'b0) begin n_err++; $display("[TB] FAIL first_valid_early: got %b want 0", obs_vld); end
      end
      if (c == 1) begin
        n_cmp++;
        if (obs_vld !== 1'b1) begin n_err++; $display("[TB] FAIL first_valid_latency: got %b want 1", obs_vld); end
      end
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL stream_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL stream_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (n_out != 1024) begin n_err++; $display("[TB] FAIL stream_count: got %0d want 1024", n_out); end
  endtask

  task automatic test_frame_sel();
    sel = 0; do_reset(); frame_sel = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 1100 && n_out < 896; c++) begin
      if (n_in >= 100) frame_sel = 1'b1;
      s_tvalid = (n_in < 896); s_tdata = W'(n_in);
      #1;
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL frame_sel_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL frame_sel_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; frame_sel = 1'b0;
    n_cmp++;
    if (n_out != 896) begin n_err++; $display("[TB] FAIL frame_sel_count: got %0d want 896", n_out); end
  endtask

  task automatic test_backpressure();
    int stall_acc, gaps;
    sel = 0; do_reset(); stall_acc = 0; gaps = 0;
    for (int c = 0; c < 300 && n_out < 40; c++) begin
      m_tready = (c >= 10);
      s_tvalid = (n_in < 40); s_tdata = W'(n_in);
      #1;
      if (c == 9) begin
        n_cmp++;
        if (stall_acc != 4 || obs_rdy !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL bp_accepts: got accepts=%0d rdy=%b want 4 0", stall_acc, obs_rdy);
        end
      end
      if (c >= 10 && !obs_vld) gaps++;
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; if (c < 10) stall_acc++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL bp_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL bp_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (gaps != 0 || n_out != 40) begin
      n_err++; $display("[TB] FAIL bp_contiguous: got gaps=%0d outs=%0d want 0 40", gaps, n_out);
    end
    n_cmp++;
    if (obs_ovf !== 1'b0) begin n_err++; $display("[TB] FAIL bp_overflow: got %b want 0", obs_ovf); end
  endtask

  task automatic test_drop();
    int drops;
    logic [W-1:0] fifth;
    sel = 1; do_reset(); drops = 0; fifth = '0;
    for (int c = 0; c < 300 && n_out < 34; c++) begin
      m_tready = (c >= 9);
      s_tvalid = (n_in < 40); s_tdata = W'(n_in);
      #1;
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (obs_ovf !== (c == 5)) begin
          n_err++; $display("[TB] FAIL drop_ovf_timing: cycle %0d got %b want %b", c, obs_ovf, (c == 5));
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (obs_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL drop_ready: got %b want 1", obs_rdy); end
      end
      if (s_tvalid && obs_rdy) begin
        if (occ < DEPTH) begin push_exp(s_tdata); occ++; end
        else drops++;
        n_in++;
      end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++; occ--;
        if (n_out == 5) fifth = obs_data;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL drop_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL drop_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (drops != 6 || fifth !== 16'd10 || n_out != 34) begin
      n_err++;
      $display("[TB] FAIL drop_pattern: got drops=%0d fifth=%0d outs=%0d want 6 10 34", drops, fifth, n_out);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_ovf !== 1'b1) begin n_err++; $display("[TB] FAIL drop_sticky: got %b want 1", obs_ovf); end
    do_reset();
    #1;
    n_cmp++;
    if (obs_ovf !== 1'b0) begin n_err++; $display("[TB] FAIL drop_ovf_clear: got %b want 0", obs_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_enable();
    int en_cyc, rdy_bad;
    sel = 0; do_reset(); m_tready = 1'b1; en_cyc = 0; rdy_bad = 0;
    for (int c = 0; c < 700 && n_out < 300; c++) begin
      en = !(n_in == 201 && en_cyc < 20);
      s_tvalid = (n_in < 300); s_tdata = W'(n_in);
      #1;
      if (!en) begin
        en_cyc++;
        if (obs_rdy) rdy_bad++;
        if (en_cyc == 20) begin
          n_cmp++;
          if (obs_vld !== 1'b0) begin n_err++; $display("[TB] FAIL en_drain: got vld=%b want 0", obs_vld); end
        end
      end
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL en_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL en_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; en = 1'b1;
    n_cmp++;
    if (rdy_bad != 0 || en_cyc != 20 || n_out != 300) begin
      n_err++;
      $display("[TB] FAIL en_window: got rdy_bad=%0d en_cyc=%0d outs=%0d want 0 20 300", rdy_bad, en_cyc, n_out);
    end
  endtask

  task automatic test_reset_midframe();
    int fill;
    sel = 0; do_reset(); m_tready = 1'b1;
    for (int c = 0; c < 400 && n_in < 300; c++) begin
      s_tvalid = 1'b1; s_tdata = W'(n_in);
      #1;
      if (obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL rstmid_pre: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL rstmid_pre: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    m_tready = 1'b0; fill = 0;
    while (fill < 20 && obs_rdy) begin
      s_tdata = W'(n_in); n_in++; fill++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (obs_rdy !== 1'b0 || obs_vld !== 1'b1) begin
      n_err++; $display("[TB] FAIL rstmid_full: got rdy=%b vld=%b want 0 1", obs_rdy, obs_vld);
    end
    rst = 1'b1; m_tready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if ({obs_rdy, obs_vld, obs_last, obs_user, obs_data} !== '0) begin
        n_err++;
        $display("[TB] FAIL rstmid_outputs: got rdy=%b vld=%b last=%b user=%0d data=%0d want all 0",
                 obs_rdy, obs_vld, obs_last, obs_user, obs_data);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; model_reset(); n_in = 0; n_out = 0;
    for (int c = 0; c < 700 && n_out < 512; c++) begin
      s_tvalid = (n_in < 512); s_tdata = W'(n_in + 1000);
      #1;
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL rstmid_post: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL rstmid_post: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (n_out != 512) begin n_err++; $display("[TB] FAIL rstmid_count: got %0d want 512", n_out); end
  endtask

  task automatic test_wrap();
    logic [15:0] users[$];
    sel = 2; do_reset(); frame_sel = 1'b1; m_tready = 1'b1;
    for (int c = 0; c < 2400 && n_out < 2048; c++) begin
      s_tvalid = (n_in < 2048); s_tdata = W'(n_in);
      #1;
      if (s_tvalid && obs_rdy) begin push_exp(s_tdata); n_in++; end
      if (obs_vld && m_tready) begin
        n_cmp++; n_out++;
        if (obs_last) users.push_back(obs_user);
        if (sb.size() == 0) begin n_err++; $display("[TB] FAIL wrap_out: unexpected data=%0d", obs_data); end
        else begin
          e = sb.pop_front();
          if ({obs_data, obs_last, obs_user} !== {e.data, e.last, e.user}) begin
            n_err++;
            $display("[TB] FAIL wrap_out: got d=%0d l=%b u=%0d want d=%0d l=%b u=%0d",
                     obs_data, obs_last, obs_user, e.data, e.last, e.user);
          end
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; frame_sel = 1'b0;
    n_cmp++;
    if (users.size() != 5) begin
      n_err++; $display("[TB] FAIL wrap_frames: got %0d frames want 5", users.size());
    end else if (users[0] !== 16'd0 || users[1] !== 16'd1 || users[2] !== 16'd2 ||
                 users[3] !== 16'd3 || users[4] !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL wrap_seq: got %0d,%0d,%0d,%0d,%0d want 0,1,2,3,0",
               users[0], users[1], users[2], users[3], users[4]);
    end
  endtask

  initial begin
    sel = 0; rst = 1'b1; en = 1'b1; frame_sel = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = '0;
    test_reset();
    @(posedge clk); #1;
    test_stream();
    test_frame_sel();
    test_backpressure();
    test_drop();
    test_enable();
    test_reset_midframe();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ospfb_axis_framer.md
Name: ospfb_axis_framer

Overview:
- Parametrised AXI-Stream framing shim for the top level of the oversampled PFB datapath.
- Buffers a real sample stream in a small FIFO, gates intake with `en`, and re-emits it with `m_tlast` marking frame boundaries and `m_tuser` carrying a frame sequence number.
- Frame length is run-time selectable between FFT_LEN (output-frame mode) and DEC_FAC (input-frame mode).
- Optional drop-on-full mode with a sticky overflow flag, for ADC-fed inputs that cannot be back-pressured.

Parameters:
- WIDTH, 16, sample width in bits (signed, passed through unmodified).
- FFT_LEN, 512, frame length when frame_sel=0.
- DEC_FAC, 384, frame length when frame_sel=1; must be <= FFT_LEN.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
- FRAME_CNT_WID, 16, width of the frame sequence counter.
- DROP_ON_FULL, 0, 0 = back-pressure when full; 1 = always ready while en=1 and drop writes when full.

Ports:
- clk  input  1  single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  intake enable; 0 blocks new input, output continues draining.
- frame_sel  input  1  0 = FFT_LEN frames, 1 = DEC_FAC frames; sampled only at frame boundaries.
- s_tdata  input  WIDTH  signed input sample.
- s_tvalid  input  1  input valid.
- s_tready  output  1  input ready.
- m_tdata  output  WIDTH  signed output sample.
- m_tvalid  output  1  output valid.
- m_tready  input  1  downstream ready.
- m_tlast  output  1  high on the last sample of each frame.
- m_tuser  output  FRAME_CNT_WID  frame number of the current output sample.
- overflow  output  1  sticky; set when an input sample was dropped.

Behaviour:
Reset:
- On a rst=1 clock edge the block returns to its reset state:
  - FIFO empty, sample counter 0, frame counter 0.
  - Active frame length = FFT_LEN, overflow = 0.
- While rst=1:
  - s_tready = 0
  - m_tvalid = 0
  - m_tlast = 0
  - m_tuser = 0
  - m_tdata = 0
- Reset mid-frame discards all buffered data. The first frame after reset starts at sample 0 with m_tuser = 0.

Handshake:
- Input accepted when s_tvalid && s_tready.
- Output transfer when m_tvalid && m_tready.
- DROP_ON_FULL=0:
  - s_tready = en && !full, from registered state.
  - No data is lost.
  - When full, a simultaneous read does not open the write in the same cycle.
- DROP_ON_FULL=1:
  - s_tready = en.
  - A valid input while full (registered state, regardless of a concurrent read) is discarded and overflow is set on the next edge.
- m_tvalid = !empty.
- m_tdata, m_tlast and m_tuser are stable while m_tvalid && !m_tready.

Latency:
- An accepted sample is visible on m_tdata with m_tvalid=1 one cycle after acceptance, when the FIFO was empty.
- Sustained throughput is 1 sample/cycle with simultaneous read and write when not full.

Framing:
- Sample counter increments on each output transfer.
- m_tlast = (cnt == len_active-1).
- On a transfer with m_tlast=1:
  - cnt wraps to 0.
  - Frame counter increments, modulo 2^FRAME_CNT_WID.
  - len_active reloads from frame_sel.
- frame_sel changes mid-frame take effect only at the next frame start.
- m_tuser = frame counter value for the whole frame, including the tlast sample.

FIFO:
- Circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits.
- full = MSBs differ and remaining bits equal.
- empty = pointers equal.

en behaviour:
- Deasserting en mid-frame does not reset counters. Framing resumes seamlessly when en returns.

overflow:
- Cleared only by rst.
- Never set when DROP_ON_FULL=0.

Test Plan:
- Reset then stream ramp 0..1023 with m_tready=1, frame_sel=0, en=1:
  - m_tlast on samples 511 and 1023.
  - m_tuser=0 for samples 0..511 and 1 for samples 512..1023.
  - First m_tvalid one cycle after the first accept.
- frame_sel toggled 0->1 at sample 100 of frame 0:
  - Frame 0 still ends at sample 511.
  - Frame 1 ends after 384 samples, at global sample 895, with m_tuser=1.
- DROP_ON_FULL=0, m_tready=0 for 10 cycles with continuous s_tvalid:
  - s_tready falls after exactly 4 accepts.
  - After m_tready=1, output is contiguous with no gaps or loss.
  - overflow stays 0.
- DROP_ON_FULL=1, same stimulus (input ramp continues):
  - Samples 0..3 retained, samples 4..9 dropped, overflow=1 and held until rst.
  - After m_tready=1, samples 10 onward follow 0..3.
- en=0 for 20 cycles mid-frame, with sample counter at 200:
  - s_tready=0, FIFO drains.
  - On resume the next sample has cnt=201 on the same m_tuser, no spurious m_tlast.
- rst pulsed at sample 300 with FIFO full:
  - All outputs 0 during reset.
  - Next frame starts with m_tuser=0 and m_tlast at sample 511.
- Frame counter wrap with FRAME_CNT_WID=2, frame_sel=1:
  - m_tuser sequence 0,1,2,3,0 across 5 frames.
